dma_xfer_scheduler: RTL and testbench
=====================================

Name: dma_xfer_scheduler

Overview:
- Sits between the user transaction interface and the reader/writer engines.
- Accepts one copy transaction of up to 2^32-1 bytes, with separate source and destination addresses.
- Splits it into transfer commands of the form {NumBytes[11:0], SrcAddr[31:0], DestAddr[31:0]}. No transfer crosses a 4 KB boundary on either address, and none exceeds MAX_XFER.
- Limits in-flight transfers, tracks completions, and pulses done once the whole transaction has retired.

Parameters:
- MAX_XFER, 2048, maximum bytes per transfer; power of two, 1..2048.
- MAX_OUTSTANDING, 4, maximum transfers issued but not yet completed; 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- trans_valid  in  1  transaction request valid.
- trans_ready  out  1  scheduler can accept a transaction.
- trans_src_addr  in  32  source start address.
- trans_dst_addr  in  32  destination start address.
- trans_num_bytes  in  32  total byte count; 0 is legal.
- xfer_valid  out  1  transfer command valid.
- xfer_ready  in  1  engines accept the transfer command.
- xfer_cmd  out  76  {NumBytes[75:64], SrcAddr[63:32], DestAddr[31:0]}.
- xfer_done  in  1  one-cycle pulse per completed transfer, in issue order.
- trans_done  out  1  one-cycle pulse when the transaction has fully retired.
- busy  out  1  high from transaction acceptance until the trans_done cycle, inclusive.
- err  out  1  sticky; set when xfer_done arrives with outstanding == 0.

Behaviour:
- Reset (async, any state): state=IDLE; trans_ready=0 during rst, 1 on the first cycle after release; xfer_valid=0; trans_done=0; busy=0; err=0; outstanding=0; remaining, src and dst registers cleared.
- IDLE:
  - trans_ready=1.
  - On trans_valid & trans_ready: latch src, dst and remaining=trans_num_bytes; busy=1 next cycle.
  - If trans_num_bytes==0: go to DRAIN, so trans_done pulses the next cycle.
  - Otherwise go to ISSUE.
- ISSUE:
  - trans_ready=0.
  - chunk = min(remaining, MAX_XFER, 4096-src[11:0], 4096-dst[11:0]). Compute in 13 bits; the result always fits in 12 bits.
  - xfer_valid = (outstanding < MAX_OUTSTANDING).
  - xfer_cmd = {chunk, src, dst}, combinational from registers and stable while xfer_valid & !xfer_ready.
  - On handshake: src += chunk, dst += chunk (32-bit wrap at 2^32 allowed, no error), remaining -= chunk, outstanding += 1.
  - If remaining-chunk==0, go to DRAIN.
- DRAIN:
  - xfer_valid=0.
  - When outstanding==0, or outstanding==1 & xfer_done: assert trans_done for one cycle, set busy=0 the following cycle, return to IDLE.
  - trans_ready reasserts the cycle after trans_done.
- Latency:
  - Transaction accepted at cycle T gives first xfer_valid at T+1 (given credit).
  - Back-to-back transfers issue every cycle while xfer_ready=1 and credit is available.
- Outstanding counter:
  - Issue handshake and xfer_done in the same cycle leave it unchanged.
  - At MAX_OUTSTANDING, xfer_valid deasserts; an xfer_done in that cycle re-enables it the next cycle, not the same cycle.
- Spurious xfer_done (outstanding==0): set err, counter holds at 0.
- xfer_done is accepted in every state.
- trans_valid is ignored outside IDLE.

Test Plan:
- src=0x1000, dst=0x2000, bytes=5000, MAX_XFER=2048, xfer_ready=1:
  - Issues three transfers: (2048,0x1000,0x2000), (2048,0x1800,0x2800), (904,0x2000,0x3000).
  - Return 3 xfer_done; trans_done pulses exactly once, one cycle after the third done.
- Boundary split, src=0x0FF0, dst=0x5008, bytes=64:
  - Issues (16,0x0FF0,0x5008), then (48,0x1000,0x5018).
- Credit stall, bytes=20480, aligned, MAX_OUTSTANDING=4, no xfer_done:
  - Exactly 4 transfers issue, then xfer_valid=0.
  - Pulse xfer_done coincident with a pending issue: count stays 4, next transfer issues one cycle later.
- Backpressure: hold xfer_ready=0 for 5 cycles with xfer_valid=1 -> xfer_cmd unchanged across all 5 cycles.
- bytes=0 -> no xfer_valid; trans_done at T+1; trans_ready=1 at T+2; err=0.
- Assert rst mid-ISSUE (outstanding=2):
  - All outputs return to reset values immediately.
  - Then a stray xfer_done sets err=1.
  - A new transaction runs to completion normally.

Source files
------------

// File: rtl/dma_xfer_scheduler.sv
// Splits one copy transaction into 4 KB-safe transfer commands, meters in-flight
// transfers against a credit limit and pulses o_trans_done once everything has retired.
//
// state   | meaning
// S_IDLE  | waiting for a transaction, o_trans_ready high
// S_ISSUE | emitting transfer commands while credit allows
// S_DRAIN | all bytes issued, waiting for the last completion
module dma_xfer_scheduler #(
   parameter int unsigned MAX_XFER        = 2048,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_trans_valid,
   output logic        o_trans_ready,
   input  logic [31:0] i_trans_src_addr,
   input  logic [31:0] i_trans_dst_addr,
   input  logic [31:0] i_trans_num_bytes,
   output logic        o_xfer_valid,
   input  logic        i_xfer_ready,
   output logic [75:0] o_xfer_cmd,
   input  logic        i_xfer_done,
   output logic        o_trans_done,
   output logic        o_busy,
   output logic        o_err
);

   localparam logic [12:0] LP_MAX_XFER = 13'(MAX_XFER);
   localparam logic [3:0]  LP_MAX_OUT  = 4'(MAX_OUTSTANDING);
   localparam logic [12:0] LP_PAGE     = 13'h1000;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t      r_state;
   logic [31:0] r_src;
   logic [31:0] r_dst;
   logic [31:0] r_remaining;
   logic [3:0]  r_outstanding;
   logic        r_trans_ready;
   logic        r_trans_done;
   logic        r_busy;
   logic        r_err;

   logic [12:0] w_rem_cap;
   logic [12:0] w_src_room;
   logic [12:0] w_dst_room;
   logic [12:0] w_min_a;
   logic [12:0] w_min_b;
   logic [12:0] w_chunk;
   logic [31:0] w_rem_next;
   logic        w_issue;
   logic        w_accept;
   logic        w_has_out;
   logic        w_retire;
   logic        w_last_retire;

   // Chunk is the minimum of four limits in 13 bits; never exceeds 2048, so bit 12 is always 0
   assign w_rem_cap  = (|r_remaining[31:12]) ? LP_PAGE : {1'b0, r_remaining[11:0]};
   assign w_src_room = LP_PAGE - {1'b0, r_src[11:0]};
   assign w_dst_room = LP_PAGE - {1'b0, r_dst[11:0]};
   assign w_min_a    = (w_rem_cap < LP_MAX_XFER) ? w_rem_cap : LP_MAX_XFER;
   assign w_min_b    = (w_src_room < w_dst_room) ? w_src_room : w_dst_room;
   assign w_chunk    = (w_min_a < w_min_b) ? w_min_a : w_min_b;
   assign w_rem_next = r_remaining - 32'(w_chunk);

   assign w_accept      = i_trans_valid & r_trans_ready;
   assign w_has_out     = (r_outstanding != 4'd0);
   assign w_retire      = i_xfer_done & w_has_out;
   assign w_last_retire = i_xfer_done & (r_outstanding == 4'd1);

   assign o_xfer_valid  = (r_state == S_ISSUE) && (r_outstanding < LP_MAX_OUT);
   assign w_issue       = o_xfer_valid & i_xfer_ready;
   assign o_xfer_cmd    = {w_chunk[11:0], r_src, r_dst};
   assign o_trans_ready = r_trans_ready;
   assign o_trans_done  = r_trans_done;
   assign o_busy        = r_busy;
   assign o_err         = r_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_src         <= '0;
         r_dst         <= '0;
         r_remaining   <= '0;
         r_outstanding <= '0;
         r_trans_ready <= 1'b0;
         r_trans_done  <= 1'b0;
         r_busy        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_outstanding <= r_outstanding + {3'b000, w_issue} - {3'b000, w_retire};
         if (i_xfer_done && !w_has_out) begin
            r_err <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_src         <= i_trans_src_addr;
                  r_dst         <= i_trans_dst_addr;
                  r_remaining   <= i_trans_num_bytes;
                  r_busy        <= 1'b1;
                  r_trans_ready <= 1'b0;
                  // Empty transaction retires immediately: done pulses in the next cycle
                  if (i_trans_num_bytes == 32'd0) begin
                     r_trans_done <= 1'b1;
                     r_state      <= S_DRAIN;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end else begin
                  r_trans_ready <= 1'b1;
               end
            end

            S_ISSUE: begin
               if (w_issue) begin
                  r_src       <= r_src + 32'(w_chunk);
                  r_dst       <= r_dst + 32'(w_chunk);
                  r_remaining <= w_rem_next;
                  if (w_rem_next == 32'd0) begin
                     r_state <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               if (r_trans_done) begin
                  r_trans_done  <= 1'b0;
                  r_busy        <= 1'b0;
                  r_trans_ready <= 1'b1;
                  r_state       <= S_IDLE;
               end else if (!w_has_out || w_last_retire) begin
                  r_trans_done <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_xfer_scheduler.sv
// Directed bench for dma_xfer_scheduler: a table of transactions with hand-computed
// transfer lists, plus sequences for zero length, backpressure, credit stall and reset.
module tb_dma_xfer_scheduler;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_trans_valid = 1'b0;
   logic        o_trans_ready;
   logic [31:0] i_trans_src_addr = '0;
   logic [31:0] i_trans_dst_addr = '0;
   logic [31:0] i_trans_num_bytes = '0;
   logic        o_xfer_valid;
   logic        i_xfer_ready = 1'b0;
   logic [75:0] o_xfer_cmd;
   logic        i_xfer_done = 1'b0;
   logic        o_trans_done;
   logic        o_busy;
   logic        o_err;

   dma_xfer_scheduler #(.MAX_XFER(2048), .MAX_OUTSTANDING(4)) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_trans_valid     (i_trans_valid),
      .o_trans_ready     (o_trans_ready),
      .i_trans_src_addr  (i_trans_src_addr),
      .i_trans_dst_addr  (i_trans_dst_addr),
      .i_trans_num_bytes (i_trans_num_bytes),
      .o_xfer_valid      (o_xfer_valid),
      .i_xfer_ready      (i_xfer_ready),
      .o_xfer_cmd        (o_xfer_cmd),
      .i_xfer_done       (i_xfer_done),
      .o_trans_done      (o_trans_done),
      .o_busy            (o_busy),
      .o_err             (o_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      logic [31:0] nbytes;
      int          n;
      logic [75:0] c0;
      logic [75:0] c1;
      logic [75:0] c2;
   } vec_t;

   vec_t        vecs[6];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          done_sent = 0;
   int          td_count = 0;
   logic [75:0] log_q[$];
   int          base, tdb, tdc, ldc;

   always @(negedge i_clk) begin
      if (!i_rst && o_xfer_valid && i_xfer_ready) log_q.push_back(o_xfer_cmd);
      if (o_trans_done) td_count++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   function automatic logic [75:0] logged(input int idx);
      if (idx < log_q.size()) return log_q[idx];
      return '1;
   endfunction

   // Present a transaction in the current cycle; returns positioned in the cycle after acceptance
   task automatic start_trans(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n,
                              output int b, output int tb);
      b = log_q.size();
      tb = td_count;
      done_sent = b;
      i_trans_src_addr  = s;
      i_trans_dst_addr  = d;
      i_trans_num_bytes = n;
      i_trans_valid     = 1'b1;
      check("accept_ready", o_trans_ready, 1'b1);
      step();
      i_trans_valid = 1'b0;
   endtask

   // Return one completion per issued transfer until trans_done is seen
   task automatic finish_trans(input int budget, output int td_cyc, output int last_done);
      td_cyc = -1;
      last_done = -1;
      for (int k = 0; k < budget; k++) begin
         step();
         if (o_trans_done) begin
            td_cyc = cyc;
            break;
         end
         if (log_q.size() > done_sent) begin
            i_xfer_done = 1'b1;
            done_sent++;
            last_done = cyc;
         end else begin
            i_xfer_done = 1'b0;
         end
      end
      i_xfer_done = 1'b0;
      check("trans_done_seen", (td_cyc >= 0), 1'b1);
   endtask

   task automatic run_vector(input int i);
      logic [75:0] exp;
      i_xfer_ready = 1'b1;
      start_trans(vecs[i].src, vecs[i].dst, vecs[i].nbytes, base, tdb);
      check($sformatf("v%0d_first_valid", i), o_xfer_valid, 1'b1);
      finish_trans(100, tdc, ldc);
      check($sformatf("v%0d_n_xfers", i), log_q.size() - base, vecs[i].n);
      for (int j = 0; j < vecs[i].n; j++) begin
         exp = (j == 0) ? vecs[i].c0 : (j == 1) ? vecs[i].c1 : vecs[i].c2;
         check($sformatf("v%0d_cmd%0d", i, j), logged(base + j), exp);
      end
      check($sformatf("v%0d_td_latency", i), tdc, ldc + 1);
      check($sformatf("v%0d_busy_in_td", i), o_busy, 1'b1);
      step();
      check($sformatf("v%0d_busy_after", i), o_busy, 1'b0);
      check($sformatf("v%0d_ready_after", i), o_trans_ready, 1'b1);
      step();
      step();
      check($sformatf("v%0d_td_once", i), td_count - tdb, 1);
   endtask

   initial begin
      vecs[0] = '{32'h1000, 32'h2000, 32'd5000, 3,
                  {12'd2048, 32'h1000, 32'h2000}, {12'd2048, 32'h1800, 32'h2800}, {12'd904, 32'h2000, 32'h3000}};
      vecs[1] = '{32'h0FF0, 32'h5008, 32'd64, 2,
                  {12'd16, 32'h0FF0, 32'h5008}, {12'd48, 32'h1000, 32'h5018}, '0};
      vecs[2] = '{32'h0100, 32'h0F00, 32'd300, 2,
                  {12'd256, 32'h0100, 32'h0F00}, {12'd44, 32'h0200, 32'h1000}, '0};
      vecs[3] = '{32'hFFFF_FFF8, 32'h0010, 32'd24, 2,
                  {12'd8, 32'hFFFF_FFF8, 32'h0010}, {12'd16, 32'h0000_0000, 32'h0018}, '0};
      vecs[4] = '{32'h0007, 32'h0009, 32'd1, 1,
                  {12'd1, 32'h0007, 32'h0009}, '0, '0};
      vecs[5] = '{32'h3000, 32'h4800, 32'd2048, 1,
                  {12'd2048, 32'h3000, 32'h4800}, '0, '0};

      #2;
      check("rst_trans_ready", o_trans_ready, 1'b0);
      check("rst_xfer_valid", o_xfer_valid, 1'b0);
      check("rst_trans_done", o_trans_done, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_err", o_err, 1'b0);
      step();
      step();
      i_rst = 1'b0;
      step();
      check("post_rst_ready", o_trans_ready, 1'b1);

      for (int i = 0; i < 6; i++) run_vector(i);

      // Zero-length transaction
      start_trans(32'h100, 32'h200, 32'd0, base, tdb);
      check("zero_td_t1", o_trans_done, 1'b1);
      check("zero_valid_t1", o_xfer_valid, 1'b0);
      check("zero_busy_t1", o_busy, 1'b1);
      step();
      check("zero_ready_t2", o_trans_ready, 1'b1);
      check("zero_td_t2", o_trans_done, 1'b0);
      check("zero_busy_t2", o_busy, 1'b0);
      check("zero_err", o_err, 1'b0);
      step();
      check("zero_no_xfers", log_q.size() - base, 0);

      // Backpressure: command must hold while not accepted
      i_xfer_ready = 1'b0;
      start_trans(32'h8000, 32'h9000, 32'd4096, base, tdb);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_valid%0d", k), o_xfer_valid, 1'b1);
         check($sformatf("bp_cmd%0d", k), o_xfer_cmd, {12'd2048, 32'h8000, 32'h9000});
         step();
      end
      check("bp_no_handshake", log_q.size() - base, 0);
      i_xfer_ready = 1'b1;
      finish_trans(100, tdc, ldc);
      check("bp_n_xfers", log_q.size() - base, 2);
      check("bp_cmd_second", logged(base + 1), {12'd2048, 32'h8800, 32'h9800});
      step();

      // Credit stall and completion coincident with issue
      start_trans(32'h10000, 32'h40000, 32'd20480, base, tdb);
      step();
      step();
      step();
      step();
      check("credit_stall_t5", o_xfer_valid, 1'b0);
      step();
      step();
      check("credit_stall_t7", o_xfer_valid, 1'b0);
      check("credit_issued4", log_q.size() - base, 4);
      i_xfer_done = 1'b1;
      done_sent++;
      step();
      check("credit_reenable", o_xfer_valid, 1'b1);
      done_sent++;
      step();
      i_xfer_done = 1'b0;
      check("credit_coincident", o_xfer_valid, 1'b1);
      step();
      check("credit_full_again", o_xfer_valid, 1'b0);
      check("credit_issued6", log_q.size() - base, 6);
      finish_trans(200, tdc, ldc);
      check("credit_n_xfers", log_q.size() - base, 10);
      check("credit_cmd4", logged(base + 4), {12'd2048, 32'h12000, 32'h42000});
      check("credit_cmd9", logged(base + 9), {12'd2048, 32'h14800, 32'h44800});
      step();

      // Reset in the middle of issuing
      start_trans(32'h20000, 32'h30000, 32'd20480, base, tdb);
      step();
      step();
      i_rst = 1'b1;
      #1;
      check("mid_rst_issued2", log_q.size() - base, 2);
      check("mid_rst_ready", o_trans_ready, 1'b0);
      check("mid_rst_valid", o_xfer_valid, 1'b0);
      check("mid_rst_td", o_trans_done, 1'b0);
      check("mid_rst_busy", o_busy, 1'b0);
      check("mid_rst_err", o_err, 1'b0);
      check("mid_rst_cmd", o_xfer_cmd, '0);
      step();
      i_rst = 1'b0;
      step();
      check("rel_ready", o_trans_ready, 1'b1);
      i_xfer_done = 1'b1;
      step();
      i_xfer_done = 1'b0;
      check("stray_err", o_err, 1'b1);
      check("stray_valid", o_xfer_valid, 1'b0);
      run_vector(0);
      check("err_sticky", o_err, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
